// File: rtl/sum_sequencer.sv
// sum_sequencer: sequenced series-sum engine.
// On start it latches N, accumulates S = 0+1+...+N one term per cycle, then
// converts S into four BCD digits with a shift-add-3 (double dabble) pass.
// The digit outputs hold the last completed result until the next DONE.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start after reset
//   LOAD    | clear accumulator, term counter k <= 1
//   ACCUM   | add k while k <= N, one term per cycle
//   CONVERT | ACC_W shift-add-3 steps on {BCD nibbles, S}
//   DONE    | result valid, digits published; start reruns
module sum_sequencer #(
  parameter int DATA_W = 6,
  parameter int ACC_W  = 11
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic [1:0]        status,
  output logic              done,
  output logic [ACC_W-1:0]  accumulator,
  output logic [3:0]        bcd_units,
  output logic [3:0]        bcd_tens,
  output logic [3:0]        bcd_hundreds,
  output logic [3:0]        bcd_thousands
);

  localparam int SR_W  = 16 + ACC_W;
  localparam int CNT_W = $clog2(ACC_W) + 1;
  localparam int PAD_W = ACC_W - DATA_W - 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(ACC_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ACCUM   = 3'd2,
    S_CONVERT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] n_q;
  logic [DATA_W:0]   k_q;
  logic [ACC_W-1:0]  acc_q;
  logic [SR_W-1:0]   sr_q;
  logic [CNT_W-1:0]  bit_q;
  logic [1:0]        status_q;
  logic              done_q;
  logic [15:0]       bcd_q;

  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_d;
  logic [ACC_W-1:0]  acc_d;
  logic              more_terms;

  // k is one bit wider than N so k = 2^DATA_W terminates the loop without wrapping
  assign more_terms = (k_q <= {1'b0, n_q});
  assign acc_d      = acc_q + {{PAD_W{1'b0}}, k_q};

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_adj[ACC_W + 4*i +: 4] >= 4'd5) begin
        sr_adj[ACC_W + 4*i +: 4] = sr_adj[ACC_W + 4*i +: 4] + 4'd3;
      end
    end
    sr_d = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Sequencer FSM with registered status, done pulse, sum and digits
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      sr_q     <= '0;
      bit_q    <= '0;
      status_q <= 2'b00;
      done_q   <= 1'b0;
      bcd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q      <= data;
            state_q  <= S_LOAD;
            status_q <= 2'b01;
          end
        end
        S_LOAD: begin
          acc_q   <= '0;
          k_q     <= {{DATA_W{1'b0}}, 1'b1};
          state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          if (more_terms) begin
            acc_q <= acc_d;
            k_q   <= k_q + 1'b1;
          end else begin
            sr_q    <= {16'b0, acc_q};
            bit_q   <= '0;
            state_q <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          sr_q  <= sr_d;
          bit_q <= bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            // Digits come from the post-shift value of the final step
            bcd_q    <= sr_d[SR_W-1 -: 16];
            state_q  <= S_DONE;
            status_q <= 2'b10;
            done_q   <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            n_q      <= data;
            state_q  <= S_LOAD;
            status_q <= 2'b01;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          status_q <= 2'b00;
        end
      endcase
    end
  end

  assign status        = status_q;
  assign done          = done_q;
  assign accumulator   = acc_q;
  assign bcd_thousands = bcd_q[15:12];
  assign bcd_hundreds  = bcd_q[11:8];
  assign bcd_tens      = bcd_q[7:4];
  assign bcd_units     = bcd_q[3:0];

endmodule

// File: tb/tb_sum_sequencer.sv
// Self-checking bench for sum_sequencer: a timeline model derived from the
// run latency (LOAD, N+1 ACCUM, 11 CONVERT, DONE) plus directed literal checks.
module tb_sum_sequencer;

  localparam int DATA_W = 6;
  localparam int ACC_W  = 11;

  logic              clock = 1'b0;
  logic              rst   = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data  = '0;
  logic [1:0]        status;
  logic              done;
  logic [ACC_W-1:0]  accumulator;
  logic [3:0]        bcd_units, bcd_tens, bcd_hundreds, bcd_thousands;

  int checks = 0;
  int errors = 0;

  sum_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clock(clock), .rst(rst), .start(start), .data(data),
    .status(status), .done(done), .accumulator(accumulator),
    .bcd_units(bcd_units), .bcd_tens(bcd_tens),
    .bcd_hundreds(bcd_hundreds), .bcd_thousands(bcd_thousands)
  );

  always #5 clock = ~clock;

  wire [15:0] dut_bcd = {bcd_thousands, bcd_hundreds, bcd_tens, bcd_units};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
  endfunction

  // Model: age = edges since start was accepted, -1 when idle/done.
  int          m_age    = -1;
  int          m_n      = 0;
  int          m_acc    = 0;
  int          m_status = 0;
  int          m_done   = 0;
  logic [15:0] m_bcd    = '0;

  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      m_age = -1; m_n = 0; m_acc = 0; m_status = 0; m_done = 0; m_bcd = '0;
    end else begin
      m_done = 0;
      if (m_age < 0) begin
        if (start) begin
          m_n = int'(data); m_age = 0; m_status = 1;
        end
      end else begin
        m_age++;
        if (m_age == 1) m_acc = 0;
        else if (m_age <= m_n + 1) m_acc = (m_age - 1) * m_age / 2;
        else if (m_age == m_n + 13) begin
          m_done = 1; m_status = 2; m_bcd = to_bcd(m_acc); m_age = -1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(posedge clock) begin
    #1;
    chk("status", int'(status), m_status);
    chk("done", int'(done), m_done);
    chk("accumulator", int'(accumulator), m_acc);
    chk("bcd", int'(dut_bcd), int'(m_bcd));
  end

  // Accept start with operand n on the next edge; start is dropped afterwards
  task automatic launch(input int n);
    @(negedge clock);
    data  = DATA_W'(n);
    start = 1'b1;
    @(posedge clock);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cnt);
    cnt = 0;
    while (cnt < bound) begin
      @(posedge clock);
      #2;
      cnt++;
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_done: no done within %0d edges", bound);
  endtask

  int cnt;
  int last, gap;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #2;
    chk("rst_status", int'(status), 0);
    chk("rst_acc", int'(accumulator), 0);
    chk("rst_bcd", int'(dut_bcd), 0);
    @(negedge clock);
    rst = 1'b1;
    repeat (2) @(posedge clock);

    // 1: N = 0
    launch(0);
    wait_done(40, cnt);
    chk("t1_latency", cnt, 13);
    chk("t1_acc", int'(accumulator), 0);
    chk("t1_bcd", int'(dut_bcd), 16'h0000);
    chk("t1_status", int'(status), 2);

    // 2: N = 10
    launch(10);
    wait_done(60, cnt);
    chk("t2_latency", cnt, 23);
    chk("t2_acc", int'(accumulator), 55);
    chk("t2_bcd", int'(dut_bcd), 16'h0055);

    // 3: N = 63, largest operand
    launch(63);
    wait_done(120, cnt);
    chk("t3_latency", cnt, 76);
    chk("t3_acc", int'(accumulator), 2016);
    chk("t3_bcd", int'(dut_bcd), 16'h2016);

    // 4: disturbances during ACCUM are ignored, then rerun from DONE
    launch(10);
    repeat (3) @(posedge clock);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      data  = 6'd40;
      start = ~start;
    end
    @(negedge clock);
    start = 1'b0;
    wait_done(60, cnt);
    chk("t4_latency", cnt, 14);
    chk("t4_acc", int'(accumulator), 55);
    chk("t4_bcd", int'(dut_bcd), 16'h0055);
    repeat (2) @(posedge clock);
    launch(20);
    repeat (10) @(posedge clock);
    #2;
    chk("t4_bcd_held", int'(dut_bcd), 16'h0055);
    chk("t4_busy", int'(status), 1);
    wait_done(60, cnt);
    chk("t4_acc2", int'(accumulator), 210);
    chk("t4_bcd2", int'(dut_bcd), 16'h0210);

    // 5: start held high, N = 3: DONE cycle plus 16 busy cycles per run
    @(negedge clock);
    data  = 6'd3;
    start = 1'b1;
    wait_done(40, cnt);
    chk("t5_bcd0", int'(dut_bcd), 16'h0006);
    for (int r = 0; r < 2; r++) begin
      wait_done(40, gap);
      chk("t5_period", gap, 17);
      chk("t5_bcd", int'(dut_bcd), 16'h0006);
    end
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("t5_hold", int'(status), 2);

    // 6: reset during CONVERT of an N = 50 run
    launch(50);
    repeat (57) @(posedge clock);
    #2;
    chk("t6_pre_busy", int'(status), 1);
    @(negedge clock);
    rst = 1'b0;
    #1;
    chk("t6_status", int'(status), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_acc", int'(accumulator), 0);
    chk("t6_bcd", int'(dut_bcd), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b1;
    last = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #2;
      if (done) last++;
    end
    chk("t6_no_done", last, 0);
    chk("t6_idle", int'(status), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
